// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and constants for the line buffer feeding the 7x7 window stage.
package sopu_pkg;
    localparam int KSIZE     = 7;
    localparam int PIX_W     = 8;
    localparam int NUM_LINES = KSIZE - 1;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} lb_state_t;
endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Valid/ready pixel stream from the UART receive path.
interface line_buffer_ctrl_if;
    logic                  pix_valid;
    sopu_pkg::pixel_t      pix_data;
    logic                  pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/line_buffer_ctrl_mem.sv
// One image row of storage: asynchronous read, synchronous write, shared address.
module line_mem
    import sopu_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pixel_t                   wdata,
    output pixel_t                   rdata
);
    pixel_t mem [DEPTH];

    // Storage is intentionally not reset; contents are only consumed once written.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: six chained row memories feeding a 7x7 window,
// row/column tracking and window-valid flagging.
// Optional macro LB_BACKPRESSURE_EN adds conv_ready, which gates pix_ready.
module line_buffer_ctrl
    import sopu_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    line_buffer_ctrl_if.slave             pix,
`ifdef LB_BACKPRESSURE_EN
    input  logic                          conv_ready,
`endif
    output logic                          shift_enable,
    output pixel_t                        uart_pixel_out,
    output pixel_t                        sr_line_0,
    output pixel_t                        sr_line_1,
    output pixel_t                        sr_line_2,
    output pixel_t                        sr_line_3,
    output pixel_t                        sr_line_4,
    output pixel_t                        sr_line_5,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          busy,
    output logic                          frame_done
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_PRIMED = ROW_W'(NUM_LINES - 1);
    localparam logic [ROW_W-1:0] ROW_WIN0   = ROW_W'(NUM_LINES);
    localparam logic [COL_W-1:0] COL_WIN0   = COL_W'(NUM_LINES);

    lb_state_t        state, state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             ready, accept, col_wrap, win_hit;
    pixel_t           rd [NUM_LINES];
    pixel_t           wd [NUM_LINES];

`ifdef LB_BACKPRESSURE_EN
    assign ready = ((state == PRIME) || (state == STREAM)) && conv_ready;
`else
    assign ready = (state == PRIME) || (state == STREAM);
`endif
    assign pix.pix_ready  = ready;
    assign accept         = pix.pix_valid && ready;
    assign shift_enable   = accept;
    assign uart_pixel_out = pix.pix_data;
    assign col_wrap       = (col == COL_LAST);
    assign win_hit        = accept && (row >= ROW_WIN0) && (col >= COL_WIN0);
    assign busy           = (state == PRIME) || (state == STREAM);
    assign frame_done     = (state == DONE);

    // Row chain: each bank takes the row above it, the newest bank takes the live pixel.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == NUM_LINES - 1) begin : g_top
            assign wd[k] = pix.pix_data;
        end else begin : g_chain
            assign wd[k] = rd[k+1];
        end
        line_mem #(.DEPTH(IMG_WIDTH)) u_mem (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (wd[k]),
            .rdata (rd[k])
        );
    end

    assign sr_line_0 = rd[0];
    assign sr_line_1 = rd[1];
    assign sr_line_2 = rd[2];
    assign sr_line_3 = rd[3];
    assign sr_line_4 = rd[4];
    assign sr_line_5 = rd[5];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Frame sequencing: prime six rows, stream the rest, one done cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRIME;
            PRIME:   if (accept && col_wrap && row == ROW_PRIMED) state_nxt = STREAM;
            STREAM:  if (accept && col_wrap && row == ROW_LAST)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position; cleared on frame start, row saturates on the last row.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col <= '0;
                if (row != ROW_LAST) row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Window flag lines up with image_window's registers after the same shift.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= win_hit;
            if (win_hit) begin
                win_row <= row - ROW_WIN0;
                win_col <= col - COL_WIN0;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on an 8x8 image.
module tb_line_buffer_ctrl;
    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
`ifdef LB_BACKPRESSURE_EN
    logic       conv_ready = 1'b1;
`endif
    logic       shift_enable, win_valid, busy, frame_done;
    logic [7:0] uart_pixel_out;
    logic [7:0] sr_line_0, sr_line_1, sr_line_2, sr_line_3, sr_line_4, sr_line_5;
    logic [2:0] win_row, win_col;
    logic [7:0] sr [6];

    always #5 clk = ~clk;

    line_buffer_ctrl_if pif();

    line_buffer_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pix            (pif),
`ifdef LB_BACKPRESSURE_EN
        .conv_ready     (conv_ready),
`endif
        .shift_enable   (shift_enable),
        .uart_pixel_out (uart_pixel_out),
        .sr_line_0      (sr_line_0),
        .sr_line_1      (sr_line_1),
        .sr_line_2      (sr_line_2),
        .sr_line_3      (sr_line_3),
        .sr_line_4      (sr_line_4),
        .sr_line_5      (sr_line_5),
        .win_valid      (win_valid),
        .win_row        (win_row),
        .win_col        (win_col),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    assign sr[0] = sr_line_0;
    assign sr[1] = sr_line_1;
    assign sr[2] = sr_line_2;
    assign sr[3] = sr_line_3;
    assign sr[4] = sr_line_4;
    assign sr[5] = sr_line_5;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frame activity, pixels accepted, expected registered outputs.
    bit         active, exp_wv, exp_fd, frame_over;
    int         n, exp_wr, exp_wc, bp_left;
    logic [7:0] wm [7][7];
    int         wins_r[$], wins_c[$];
    int         list_r [4] = '{0, 0, 1, 1};
    int         list_c [4] = '{0, 1, 0, 1};
    logic [7:0] p54 [6] = '{8'd6, 8'd14, 8'd22, 8'd30, 8'd38, 8'd46};

    function automatic logic [7:0] img(input int r, input int c);
        return 8'((r * W + c) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        active = 0; n = 0; exp_wv = 0; exp_fd = 0; exp_wr = 0; exp_wc = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit st);
        bit         rdy, acc;
        int         r, c, bad;
        logic [7:0] col_in [7];
        @(negedge clk);
        pif.pix_valid = v;
        pif.pix_data  = d;
        start         = st;
        rdy           = active;
`ifdef LB_BACKPRESSURE_EN
        conv_ready = !(bp_left > 0 && n == 55);
        if (!conv_ready) bp_left--;
        rdy = rdy && conv_ready;
`endif
        acc = v && rdy;
        r = n / W;
        c = n % W;
        #1;
        chk("pix_ready", pif.pix_ready, rdy);
        chk("shift_enable", shift_enable, acc);
        chk("uart_pixel", uart_pixel_out, d);
        if (acc) begin
            for (int k = 0; k < 6; k++) begin
                col_in[k] = sr[k];
                if (r - 6 + k >= 0) chk("sr_line", sr[k], img(r - 6 + k, c));
                if (n == 54) chk("sr_line_px54", sr[k], p54[k]);
            end
            col_in[6] = d;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            for (int i = 0; i < 7; i++) begin
                for (int j = 0; j < 6; j++) wm[i][j] = wm[i][j+1];
                wm[i][6] = col_in[i];
            end
        end
        exp_wv = acc && r >= 6 && c >= 6;
        if (exp_wv) begin
            exp_wr = r - 6;
            exp_wc = c - 6;
        end
        if (st && !active && !exp_fd) begin
            active = 1;
            n      = 0;
        end
        exp_fd = acc && (n == W * H - 1);
        if (exp_fd) frame_over = 1;
        if (acc) begin
            n++;
            if (n == W * H) active = 0;
        end
        chk("win_valid", win_valid, exp_wv);
        chk("frame_done", frame_done, exp_fd);
        chk("busy", busy, active);
        if (win_valid === 1'b1) begin
            wins_r.push_back(int'(win_row));
            wins_c.push_back(int'(win_col));
        end
        if (exp_wv) begin
            chk("win_row", win_row, exp_wr);
            chk("win_col", win_col, exp_wc);
            bad = 0;
            for (int i = 0; i < 7; i++)
                for (int j = 0; j < 7; j++)
                    if (wm[i][j] !== img(exp_wr + i, exp_wc + j)) bad++;
            chk("win_pixels", bad, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        pif.pix_valid = 0;
        start = 0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_win_valid", win_valid, exp_wv);
        chk("rst_win_row", win_row, exp_wr);
        chk("rst_win_col", win_col, exp_wc);
        chk("rst_busy", busy, active);
        chk("rst_frame_done", frame_done, exp_fd);
        @(negedge clk);
        rst = 1;
    endtask

    // mode 0 continuous, 1 random gaps, 2 stray start pulses, 3 conv stall.
    task automatic run_frame(input int mode, input int abort_after);
        bit v, st;
        wins_r.delete();
        wins_c.delete();
        frame_over = 0;
        bp_left = (mode == 3) ? 5 : 0;
        step(0, 8'($urandom), 1);
        for (int cyc = 0; cyc < 1000 && !frame_over; cyc++) begin
            v  = (mode == 1) ? bit'($urandom_range(0, 1)) : 1'b1;
            st = (mode == 2) && (cyc % 9 == 4);
            step(v, v ? img(n / W, n % W) : 8'($urandom), st);
            if (abort_after >= 0 && n > abort_after) return;
        end
        chk("frame_end", frame_over, 1);
        chk("win_count", wins_r.size(), 4);
        for (int i = 0; i < 4 && i < wins_r.size(); i++) begin
            chk("win_list_row", wins_r[i], list_r[i]);
            chk("win_list_col", wins_c[i], list_c[i]);
        end
        step(0, 8'($urandom), 0);
    endtask

    initial begin
        pif.pix_valid = 0;
        pif.pix_data  = 0;
        model_reset();
        do_reset();
        chk("rst_pix_ready", pif.pix_ready, 0);
        repeat (5) step(1, 8'($urandom), 0);
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(0, 40);
        do_reset();
        run_frame(2, -1);
`ifdef LB_BACKPRESSURE_EN
        run_frame(3, -1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Upstream feeder for the 7x7 image_window stage.
- Accepts a raster-order 8-bit pixel stream from the UART receive path through a valid/ready handshake.
- Keeps the previous six image rows in six line memories. Drives image_window's shift_enable, sr_line_0_in..sr_line_5_in and uart_pixel_in.
- Tracks row/column position and flags when the window holds a complete, in-image 7x7 patch for the conv block.

Parameters:
IMG_WIDTH, 28, pixels per row; must be >= 7
IMG_HEIGHT, 28, rows per frame; must be >= 7

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
pix_valid  in  1  upstream pixel valid
pix_data  in  8  upstream pixel
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
shift_enable  out  1  to image_window; equals pix_valid && pix_ready (combinational)
uart_pixel_out  out  8  to image_window uart_pixel_in; equals pix_data
sr_line_0 .. sr_line_5  out  8 each  to image_window sr_line_k_in; line 0 = oldest row (r-6), line 5 = row r-1, all at current column
win_valid  out  1  registered; window holds a valid 7x7 patch this cycle
win_row  out  $clog2(IMG_HEIGHT)  top-left row of valid window
win_col  out  $clog2(IMG_WIDTH)  top-left column of valid window
busy  out  1  high in PRIME/STREAM
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE; col=0, row=0; win_valid=0, win_row=0, win_col=0, busy=0, frame_done=0.
- Line memories are not reset. sr_line_* are undefined until written and are never qualified by win_valid before that.
- Reset mid-frame aborts the frame. No flush. The next frame requires start.
- FSM states:
  - IDLE: pix_ready=0. start -> PRIME.
  - PRIME: rows 0..5. pix_ready=1. On accept of col=W-1, row=5 -> STREAM.
  - STREAM: rows 6..H-1. pix_ready=1. On accept of col=W-1, row=H-1 -> DONE.
  - DONE: single cycle. pix_ready=0, frame_done=1 -> IDLE.
- start outside IDLE is ignored.
- Accept (shift_enable=1), with current col/row:
  - sr_line_k = bank[k][col] (combinational read-before-write).
  - At the edge: bank5[col]<=pix_data; bank[k][col]<=bank[k+1][col] for k=0..4.
  - col increments. At W-1, col wraps to 0 and row increments. row is held after the last row; the FSM exits anyway.
- win_valid is registered. It is 1 in the cycle after an accept with row>=6 and col>=6; otherwise 0.
  - On that cycle: win_row=row-6, win_col=col-6.
  - Latency: accepted pixel -> win_valid = 1 cycle, aligned with image_window's updated registers.
- Windows straddling a row wrap (col<6) are never flagged.
- Windows per frame = (W-6)*(H-6).
- pix_valid low: no shift, counters hold, win_valid=0 next cycle.
- Gaps in pix_valid are allowed at any position.

Optional Feature:
- Macro: LB_BACKPRESSURE_EN.
- Defined:
  - Adds input conv_ready (1 bit). pix_ready is additionally ANDed with conv_ready.
  - The window never shifts while the conv block is stalled.
  - Counter and valid rules are unchanged.
- Undefined: port absent; pix_ready as above. The conv block must accept one window per cycle.

Decomposition:
- Package sopu_pkg:
  - KSIZE=7, PIX_W=8, NUM_LINES=KSIZE-1.
  - lb_state_t enum {IDLE, PRIME, STREAM, DONE}.
  - pixel_t typedef logic [PIX_W-1:0].
- Sub-module line_mem: one IMG_WIDTH x 8 memory, single address, asynchronous read, synchronous write-enable.
  - Instantiated NUM_LINES times in a generate loop.
  - Chaining and FSM/counters stay in line_buffer_ctrl.

Test Plan (W=H=8, pixel value = row*8+col, mod 256):
- Reset then idle: pix_valid=1 without start -> pix_ready=0, no shift_enable, win_valid=0 throughout.
- Continuous frame: start, 64 back-to-back pixels.
  - win_valid pulses exactly 4 times, first in the cycle after pixel 54.
  - At that point image_window holds 00=0 and 66=54; win_row/win_col = (0,0),(0,1),(1,0),(1,1).
  - frame_done is 1 in the cycle after pixel 63 is accepted.
- Pixel 54 accept: sr_line_0..5 = 6,14,22,30,38,46 and uart_pixel_out=54.
- Random pix_valid gaps (50% duty): same 4 windows, same contents, same coordinates as the continuous case.
- Reset asserted after pixel 40, then a fresh start and full frame:
  - Output identical to the continuous case.
  - start pulses while busy have no effect.
- LB_BACKPRESSURE_EN defined:
  - conv_ready=0 for 5 cycles at pixel 55 -> pix_ready=0, no shift.
  - win_valid resumes after release, giving the same 4 windows in total.
